// File: rtl/gerenciador_acesso_pkg.sv
// Shared types, defaults and comparator-input helpers for the access-profile controller.
package gerenciador_acesso_pkg;

  localparam int unsigned SESSION_LEN_DEF = 16;
  localparam int unsigned FUNC_W_DEF      = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SESSION,
    DONE
  } estado_t;

  typedef struct packed {
    logic r0;
    logic r1;
    logic diff;
    logic p;
  } snap_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } cmp_t;

  function automatic cmp_t calc_cmp(input snap_t s);
    cmp_t v;
    v.a = s.r0 & (s.diff | ~s.p);
    v.b = s.r1;
    v.c = s.r0 & s.r1 & s.diff;
    return v;
  endfunction

  // Grants a correct comparator should return for a snapshot: {exp1, exp0}
  function automatic logic [1:0] calc_exp(input snap_t s);
    logic e0;
    logic e1;
    e0 = s.r0 & (s.diff | ~s.p | ~s.r1);
    e1 = s.r1 & (s.diff | s.p | ~s.r0);
    return {e1, e0};
  endfunction

endpackage

// File: rtl/contador_sessao.sv
// Loadable session down-counter: loads SESSION_LEN-1, decrements on enable, stops at zero.
module contador_sessao
  import gerenciador_acesso_pkg::*;
#(
  parameter int unsigned SESSION_LEN = SESSION_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero_c
);

  localparam int unsigned CNT_W = $clog2(SESSION_LEN);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SESSION_LEN - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/gerenciador_acesso_perfis.sv
// Initiator-side controller for the two-profile priority comparator and timed access sessions.
// Optional GRANT_CHECK_EN: checks returned grants against the snapshot and flags grant_err.
module gerenciador_acesso_perfis
  import gerenciador_acesso_pkg::*;
#(
  parameter int unsigned SESSION_LEN = SESSION_LEN_DEF,
  parameter int unsigned FUNC_W      = FUNC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [FUNC_W-1:0] func0,
  input  logic [FUNC_W-1:0] func1,
  input  logic              prio_sel,
  input  logic              rel0,
  input  logic              rel1,
  output logic              cmp_a,
  output logic              cmp_b,
  output logic              cmp_c,
  input  logic              prioridadefinal0,
  input  logic              prioridadefinal1,
  output logic              acesso0,
  output logic              acesso1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic              grant_err
);

  estado_t    r_state;
  estado_t    w_state_next;
  cmp_t       r_cmp;
  cmp_t       w_cmp_next;
  logic [1:0] r_acc;
  logic [1:0] w_acc_next;
  logic [1:0] r_gnt;
  logic [1:0] w_gnt_next;
  logic [1:0] r_done;
  logic [1:0] w_done_next;
  logic       r_busy;
  logic       w_load;
  logic       w_en;
  logic       w_cnt_zero;
  logic       w_req_any;
  logic [1:0] w_grants;
  snap_t      w_snap;

  assign w_req_any = req0 | req1;
  assign w_grants  = {prioridadefinal1, prioridadefinal0};
  assign w_snap    = '{r0: req0, r1: req1, diff: (func0 != func1), p: prio_sel};

  contador_sessao #(
    .SESSION_LEN(SESSION_LEN)
  ) u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_en    (w_en),
    .o_zero_c(w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    w_state_next = r_state;
    w_cmp_next   = r_cmp;
    w_acc_next   = r_acc;
    w_gnt_next   = r_gnt;
    w_done_next  = 2'b00;
    w_load       = 1'b0;
    w_en         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_state_next = ARB;
          w_cmp_next   = calc_cmp(w_snap);
        end
      end
      ARB: begin
        if (w_grants != 2'b00) begin
          w_state_next = SESSION;
          w_acc_next   = w_grants;
          w_gnt_next   = w_grants;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
          w_cmp_next   = '0;
        end
      end
      SESSION: begin
        w_en       = 1'b1;
        w_acc_next = r_acc & ~{rel1, rel0};
        // expiry and last release collapse into one end of session
        if (w_cnt_zero || (w_acc_next == 2'b00)) begin
          w_state_next = DONE;
          w_acc_next   = 2'b00;
          w_done_next  = r_gnt;
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_cmp_next   = '0;
        w_gnt_next   = 2'b00;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmp  <= '0;
      r_acc  <= 2'b00;
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
      r_busy <= 1'b0;
    end else begin
      r_cmp  <= w_cmp_next;
      r_acc  <= w_acc_next;
      r_gnt  <= w_gnt_next;
      r_done <= w_done_next;
      r_busy <= (w_state_next != IDLE);
    end
  end

  assign cmp_a   = r_cmp.a;
  assign cmp_b   = r_cmp.b;
  assign cmp_c   = r_cmp.c;
  assign acesso0 = r_acc[0];
  assign acesso1 = r_acc[1];
  assign done0   = r_done[0];
  assign done1   = r_done[1];
  assign busy    = r_busy;

`ifdef GRANT_CHECK_EN
  snap_t      r_snap;
  logic       r_grant_err;
  logic [1:0] w_exp;

  assign w_exp = calc_exp(r_snap);

  // Sticky flag: comparator disagreed with the grants implied by the snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snap      <= '0;
      r_grant_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_req_any) begin
        r_snap <= w_snap;
      end
      if ((r_state == ARB) && (w_exp != w_grants)) begin
        r_grant_err <= 1'b1;
      end
    end
  end

  assign grant_err = r_grant_err;
`else
  assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_gerenciador_acesso_perfis.sv
// Scoreboard bench for gerenciador_acesso_perfis with a behavioural priority comparator.
module tb_gerenciador_acesso_perfis;

  localparam int unsigned FUNC_W = 3;
  localparam int EV_ARB   = 0;
  localparam int EV_START = 1;
  localparam int EV_REL   = 2;
  localparam int EV_DONE  = 3;

`ifdef GRANT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [FUNC_W-1:0] func0 = '0;
  logic [FUNC_W-1:0] func1 = '0;
  logic              prio_sel = 1'b0;
  logic              rel0 = 1'b0;
  logic              rel1 = 1'b0;
  logic              force_deny = 1'b0;
  logic              cmp_a, cmp_b, cmp_c;
  logic              prioridadefinal0, prioridadefinal1;
  logic              acesso0, acesso1, done0, done1, busy, grant_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: equal-function ties resolved by a; c marks distinct functions with both requesting
  assign prioridadefinal0 = force_deny ? 1'b0 : cmp_a;
  assign prioridadefinal1 = force_deny ? 1'b0 : (cmp_b & (cmp_c | ~cmp_a));

  gerenciador_acesso_perfis #(
    .SESSION_LEN(16),
    .FUNC_W     (FUNC_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0            (req0),
    .req1            (req1),
    .func0           (func0),
    .func1           (func1),
    .prio_sel        (prio_sel),
    .rel0            (rel0),
    .rel1            (rel1),
    .cmp_a           (cmp_a),
    .cmp_b           (cmp_b),
    .cmp_c           (cmp_c),
    .prioridadefinal0(prioridadefinal0),
    .prioridadefinal1(prioridadefinal1),
    .acesso0         (acesso0),
    .acesso1         (acesso1),
    .done0           (done0),
    .done1           (done1),
    .busy            (busy),
    .grant_err       (grant_err)
  );

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] data;
  } evt_t;

  evt_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void push(input int k, input int c, input logic [3:0] d);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
  endtask

  task automatic observe(input int k, input logic [3:0] d);
    evt_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%b, none expected", k, cyc, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.cyc == cyc && e.data == d) n_pass++;
      else $display("FAIL event: got kind=%0d cyc=%0d data=%b expected kind=%0d cyc=%0d data=%b",
                    k, cyc, d, e.kind, e.cyc, e.data);
    end
  endtask

  // Monitor: turns output activity into events and checks them against the queue
  logic [1:0] prev_acc = 2'b00;
  logic       prev_busy = 1'b0;
  bit         mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !prev_busy) observe(EV_ARB, {1'b0, cmp_a, cmp_b, cmp_c});
      if ({acesso1, acesso0} != 2'b00 && prev_acc == 2'b00) observe(EV_START, {2'b00, acesso1, acesso0});
      else if ({acesso1, acesso0} != 2'b00 && {acesso1, acesso0} != prev_acc)
        observe(EV_REL, {2'b00, acesso1, acesso0});
      if (done0 || done1) observe(EV_DONE, {acesso1, acesso0, done1, done0});
      prev_acc  = {acesso1, acesso0};
      prev_busy = busy;
    end
  end

  task automatic go(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int t;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_cmp", 32'({cmp_a, cmp_b, cmp_c}), 32'd0);
    chk("reset_acc_done", 32'({acesso1, acesso0, done1, done0}), 32'd0);
    chk("reset_busy_err", 32'({busy, grant_err}), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Profile 0 alone; rel1 while profile 1 idle is ignored
    t = cyc; req0 = 1'b1; func0 = 3'd2; func1 = 3'd0; prio_sel = 1'b0;
    push(EV_ARB, t + 1, 4'b0100); push(EV_START, t + 2, 4'b0001); push(EV_DONE, t + 18, 4'b0001);
    go(t + 1); req0 = 1'b0;
    go(t + 5); rel1 = 1'b1;
    go(t + 6); rel1 = 1'b0;
    go(t + 10);
    chk("mid_session_busy_acc", 32'({busy, acesso1, acesso0}), 32'b101);
    go(t + 20);

    // Both requests, different functions: both granted, done in the same cycle
    t = cyc; req0 = 1'b1; req1 = 1'b1; func0 = 3'd1; func1 = 3'd5;
    push(EV_ARB, t + 1, 4'b0111); push(EV_START, t + 2, 4'b0011); push(EV_DONE, t + 18, 4'b0011);
    go(t + 1); req0 = 1'b0; req1 = 1'b0;
    go(t + 20);

    // Equal functions, priority to profile 1; held req0 re-arbitrated afterwards
    t = cyc; req0 = 1'b1; req1 = 1'b1; func0 = 3'd3; func1 = 3'd3; prio_sel = 1'b1;
    push(EV_ARB, t + 1, 4'b0010); push(EV_START, t + 2, 4'b0010); push(EV_DONE, t + 18, 4'b0010);
    push(EV_ARB, t + 20, 4'b0100); push(EV_START, t + 21, 4'b0001); push(EV_DONE, t + 37, 4'b0001);
    go(t + 1); req1 = 1'b0; prio_sel = 1'b0;
    go(t + 20); req0 = 1'b0;
    go(t + 39);

    // Both granted, profile 0 releases at session cycle 3
    t = cyc; req0 = 1'b1; req1 = 1'b1; func0 = 3'd1; func1 = 3'd5;
    push(EV_ARB, t + 1, 4'b0111); push(EV_START, t + 2, 4'b0011);
    push(EV_REL, t + 5, 4'b0010); push(EV_DONE, t + 18, 4'b0011);
    go(t + 1); req0 = 1'b0; req1 = 1'b0;
    go(t + 4); rel0 = 1'b1;
    go(t + 5); rel0 = 1'b0;
    go(t + 20);

    // Comparator returns no grant: back to IDLE, error flag only with the checker
    t = cyc; force_deny = 1'b1; req0 = 1'b1; func0 = 3'd2; func1 = 3'd0;
    push(EV_ARB, t + 1, 4'b0100);
    go(t + 1); req0 = 1'b0;
    go(t + 2);
    chk("deny_idle_busy", 32'(busy), 32'd0);
    chk("deny_cmp_cleared", 32'({cmp_a, cmp_b, cmp_c}), 32'd0);
    chk("deny_grant_err", 32'(grant_err), 32'(EXP_ERR));
    go(t + 4); force_deny = 1'b0;
    chk("grant_err_sticky", 32'(grant_err), 32'(EXP_ERR));

    // Reset during session cycle 5 aborts without a done pulse
    t = cyc; req0 = 1'b1; req1 = 1'b1; func0 = 3'd1; func1 = 3'd5;
    push(EV_ARB, t + 1, 4'b0111); push(EV_START, t + 2, 4'b0011);
    go(t + 1); req0 = 1'b0; req1 = 1'b0;
    go(t + 6); rst_n = 1'b0;
    go(t + 7);
    chk("midreset_cmp", 32'({cmp_a, cmp_b, cmp_c}), 32'd0);
    chk("midreset_acc_done", 32'({acesso1, acesso0, done1, done0}), 32'd0);
    chk("midreset_busy_err", 32'({busy, grant_err}), 32'd0);
    rst_n = 1'b1;
    go(t + 30);

    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gerenciador_acesso_perfis.md
Name: gerenciador_acesso_perfis

Overview:
Initiator-side controller for the two-profile priority comparator. Snapshots the profile requests and function codes, and drives the comparator inputs cmp_a, cmp_b and cmp_c from registers. It samples the returned grants prioridadefinal0/1, then runs a timed access session for the granted profile(s). Sits between the profile request logic and the combinational priority comparator.

Parameters:
SESSION_LEN, 16, session length in clock cycles (≥2).
FUNC_W, 3, width of each profile function code.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset: one clock; reset is synchronous and active-low.
req0  in  1  profile 0 access request (level, held until served).
req1  in  1  profile 1 access request (level).
func0  in  FUNC_W  profile 0 function code.
func1  in  FUNC_W  profile 1 function code.
prio_sel  in  1  priority holder when functions are equal (0 = profile 0).
rel0  in  1  profile 0 early release (pulse).
rel1  in  1  profile 1 early release (pulse).
cmp_a  out  1  comparator input a (registered).
cmp_b  out  1  comparator input b (registered).
cmp_c  out  1  comparator input c (registered).
prioridadefinal0  in  1  comparator grant, profile 0.
prioridadefinal1  in  1  comparator grant, profile 1.
acesso0  out  1  profile 0 session active.
acesso1  out  1  profile 1 session active.
done0  out  1  one-cycle pulse: profile 0 session ended.
done1  out  1  one-cycle pulse: profile 1 session ended.
busy  out  1  FSM not in IDLE.
grant_err  out  1  sticky error flag (only with the optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs are 0, including the counter, the snapshots and grant_err.
- Reset mid-session aborts immediately. No done pulse is issued.
- FSM states: IDLE, ARB, SESSION, DONE.
- IDLE, when req0|req1:
  - Snapshot s_r0, s_r1, s_diff = (func0 != func1) and s_p = prio_sel.
  - Next cycle, enter ARB with these registered values:
    - cmp_a = s_r0 & (s_diff | ~s_p)
    - cmp_b = s_r1
    - cmp_c = s_r0 & s_r1 & s_diff
- ARB lasts exactly 1 cycle. Grants are sampled at its closing edge, giving request-to-acesso latency of 2 cycles.
  - Any grant: acesso0/1 = sampled grants, counter = SESSION_LEN-1, go to SESSION.
  - No grant: go to IDLE.
- cmp_* are held during SESSION and cleared on return to IDLE.
- SESSION:
  - Counter decrements each cycle.
  - relX while acesso X=1 clears acesso X the next cycle.
  - relX while acesso X=0 is ignored.
  - Go to DONE when the counter reaches 0 or no acesso remains. Simultaneous expiry and release counts as a single end.
- DONE, 1 cycle:
  - doneX = 1 for every profile granted at ARB, whether it released early or expired.
  - All acesso outputs are 0.
  - Return to IDLE.
- Requests arriving outside IDLE are not latched.
- A denied request that stays high is re-arbitrated on the next IDLE cycle.
- busy = (state != IDLE).
- Counter width: $clog2(SESSION_LEN). It never wraps below 0.

Optional Feature:
GRANT_CHECK_EN.
- Defined:
  - Expected grants are computed internally from the snapshot: exp0 = s_r0 & (s_diff | ~s_p | ~s_r1); exp1 = s_r1 & (s_diff | s_p | ~s_r0).
  - A mismatch against the sampled grants in ARB sets grant_err, which stays set until reset.
  - The session still follows the received grants.
- Undefined: grant_err is tied to 0 and no checker logic exists.

Decomposition:
- Package gerenciador_acesso_pkg holds:
  - the state enum (IDLE, ARB, SESSION, DONE);
  - the default constants for SESSION_LEN and FUNC_W;
  - a function computing cmp_a/b/c from the snapshot.
- One natural sub-module: contador_sessao, a loadable down-counter with load, enable and zero flag, parameterized by SESSION_LEN.

Test Plan:
- req0=1 only, func0=2 -> cmp a,b,c = 1,0,0 in ARB; acesso0=1 two cycles after req; done0 pulse after 16 session cycles; acesso1 stays 0.
- req0=req1=1, func0=1, func1=5 -> a,b,c = 1,1,1; both acesso=1; done0 and done1 pulse in the same cycle.
- req0=req1=1, func0=func1=3, prio_sel=1 -> a,b,c = 0,1,0; only acesso1=1; req0 held high -> re-arbitrated after done1, acesso0=1.
- Both granted, rel0 at session cycle 3 -> acesso0=0 from cycle 4; acesso1 runs to expiry; DONE pulses both done0 and done1.
- rst_n=0 during SESSION cycle 5 -> next edge: all outputs 0, IDLE, no done pulse.
- GRANT_CHECK_EN: comparator forced to return 0,0 for req0 only -> grant_err=1 sticky; FSM returns to IDLE.
